// File: rtl/flex_bus_pkg.sv
// Shared definitions for flex bus slaves: bus widths, register index width
// and the access FSM state encoding.
package flex_bus_pkg;

   localparam int BB_ADDR_BUS_WIDTH = 16;
   localparam int BB_DATA_BUS_WIDTH = 16;

   // Register index width; a slave holds at most 16 registers.
   localparam int IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      ACK
   } flex_state_t;

endpackage

// File: rtl/flex_addr_decode.sv
// Window decoder for flex bus slaves: reports whether addr falls inside
// [base_addr, base_addr+reg_count-1] and the register index within it.
module flex_addr_decode
   import flex_bus_pkg::*;
#(
   parameter int                        addr_bus_width = BB_ADDR_BUS_WIDTH,
   parameter logic [addr_bus_width-1:0] base_addr      = 'h0100,
   parameter int                        reg_count      = 4
)(
   input  logic [addr_bus_width-1:0] addr,
   output logic                      hit,
   output logic [IDX_W-1:0]          index
);

   // Bounds are held one bit wider so a window ending at the top of the
   // address space cannot wrap around.
   localparam logic [addr_bus_width:0] WIN_LO = {1'b0, base_addr};
   localparam logic [addr_bus_width:0] WIN_HI =
      WIN_LO + (addr_bus_width+1)'(reg_count - 1);

   logic [addr_bus_width:0] addr_ext;

   // Compare the address against the window and derive the register offset.
   always_comb begin
      addr_ext = {1'b0, addr};
      hit      = (addr_ext >= WIN_LO) && (addr_ext <= WIN_HI);
      index    = IDX_W'(addr - base_addr);
   end

endmodule

// File: rtl/flex_reg_slave.sv
// Register-bank slave for the flex bus: up to 16 registers in a contiguous
// window, read-only entries mirror hw_in, dtack/data_r_act handshake with a
// programmable read wait and an acknowledge timeout.
module flex_reg_slave
   import flex_bus_pkg::*;
#(
   parameter int                        addr_bus_width = BB_ADDR_BUS_WIDTH,
   parameter int                        data_bus_width = BB_DATA_BUS_WIDTH,
   parameter logic [addr_bus_width-1:0] base_addr      = 'h0100,
   parameter int                        reg_count      = 4,
   parameter logic [15:0]               ro_mask        = 16'h0000,
   parameter int                        read_wait      = 0,
   parameter int                        ack_timeout    = 255
)(
   input  logic                                clock,
   input  logic                                reset,
   input  logic [addr_bus_width-1:0]           addr,
   input  logic [data_bus_width-1:0]           data_w,
   output logic [data_bus_width-1:0]           data_r,
   input  logic                                addr_strobe,
   input  logic                                read_trg,
   input  logic                                write_trg,
   input  logic                                read_fin,
   input  logic                                write_fin,
   input  logic                                event_trg,
   output logic                                dtack,
   output logic                                data_r_act,
   input  logic [reg_count*data_bus_width-1:0] hw_in,
   output logic [reg_count*data_bus_width-1:0] reg_out,
   output logic [reg_count-1:0]                wr_strobe
);

   localparam logic [2:0] WAIT_LAST = 3'((read_wait > 0) ? read_wait - 1 : 0);
   localparam logic [7:0] TO_LAST   = 8'(ack_timeout - 1);

   flex_state_t                         state, next_state;
   logic [2:0]                          wait_cnt;
   logic [7:0]                          to_cnt;
   logic [IDX_W-1:0]                    idx_q, dec_idx, sel_idx;
   logic                                dec_hit;
   logic                                rd_q;
   logic                                accept_wr, accept_rd;
   logic [data_bus_width-1:0]           data_r_q, rd_src;
   logic [reg_count*data_bus_width-1:0] reg_q;
   logic [reg_count-1:0]                wr_strobe_q;
   logic                                unused_ok;

   // event_trg carries no meaning for a register slave.
   assign unused_ok = &{1'b0, event_trg};

   flex_addr_decode #(
      .addr_bus_width(addr_bus_width),
      .base_addr     (base_addr),
      .reg_count     (reg_count)
   ) u_decode (
      .addr (addr),
      .hit  (dec_hit),
      .index(dec_idx)
   );

   // Next-state logic: accept only from IDLE, write wins over read.
   always_comb begin
      next_state = state;
      accept_wr  = 1'b0;
      accept_rd  = 1'b0;
      case (state)
         IDLE: begin
            if (addr_strobe && dec_hit) begin
               if (write_trg) begin
                  accept_wr  = 1'b1;
                  next_state = ACK;
               end else if (read_trg) begin
                  accept_rd  = 1'b1;
                  next_state = (read_wait > 0) ? RD_WAIT : ACK;
               end
            end
         end
         RD_WAIT: begin
            if (wait_cnt == WAIT_LAST) next_state = ACK;
         end
         ACK: begin
            if (read_fin || write_fin || !addr_strobe || (to_cnt == TO_LAST))
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Read source: a zero-wait read uses the live decode, otherwise the
   // index captured at acceptance.
   always_comb begin
      sel_idx = (state == IDLE) ? dec_idx : idx_q;
      rd_src  = '0;
      for (int i = 0; i < reg_count; i++) begin
         if (sel_idx == IDX_W'(i))
            rd_src = ro_mask[i] ? hw_in[i*data_bus_width +: data_bus_width]
                                : reg_q[i*data_bus_width +: data_bus_width];
      end
   end

   // State register plus the read-wait and acknowledge-timeout counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         to_cnt   <= '0;
         idx_q    <= '0;
         rd_q     <= 1'b0;
      end else begin
         state    <= next_state;
         wait_cnt <= (state == RD_WAIT) ? wait_cnt + 3'd1 : 3'd0;
         to_cnt   <= (state == ACK && next_state == ACK) ? to_cnt + 8'd1 : 8'd0;
         if (accept_rd) idx_q <= dec_idx;
         if (accept_rd) rd_q <= 1'b1;
         else if (next_state == IDLE) rd_q <= 1'b0;
      end
   end

   // Register bank writes; read-only entries are acknowledged but untouched.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         reg_q       <= '0;
         wr_strobe_q <= '0;
      end else begin
         wr_strobe_q <= '0;
         for (int i = 0; i < reg_count; i++) begin
            if (accept_wr && dec_idx == IDX_W'(i) && !ro_mask[i]) begin
               reg_q[i*data_bus_width +: data_bus_width] <= data_w;
               wr_strobe_q[i] <= 1'b1;
            end
         end
      end
   end

   // Read data is captured on ACK entry, held through ACK, zero elsewhere.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_r_q <= '0;
      end else if (next_state != ACK) begin
         data_r_q <= '0;
      end else if (accept_rd || state == RD_WAIT) begin
         data_r_q <= rd_src;
      end
   end

   assign data_r     = data_r_q;
   assign dtack      = (state == ACK);
   assign data_r_act = rd_q;
   assign reg_out    = reg_q;
   assign wr_strobe  = wr_strobe_q;

endmodule
